flag_cond_unit: RTL and testbench

- Consumer side of the ALU status path: the ALU's zero/negative/carry/overflow flag outputs feed this block.
- Latches the flags into a status register.
- Evaluates 4-bit condition codes against the latched flags and returns a taken/not-taken result over a valid/ready handshake.
- Sits between the ALU flag outputs and the branch/sequencing logic.

---
 rtl/flag_cond_unit_if.sv | 30 +++
 rtl/flag_cond_unit.sv | 101 ++++++++++
 tb/tb_flag_cond_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/flag_cond_unit_if.sv
// Flag/condition bus between the ALU status path and the branch logic.
// The master drives flags, condition requests and result backpressure;
// the slave (flag_cond_unit) returns the latched flags and the taken result.
interface flag_cond_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             flag_we;
    logic             z_in;
    logic             n_in;
    logic             c_in;
    logic             v_in;
    logic             cond_valid;
    logic [3:0]       cond;
    logic             cond_ready;
    logic             take_valid;
    logic             take;
    logic             take_ready;
    logic [3:0]       flags_out;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output flag_we, z_in, n_in, c_in, v_in, cond_valid, cond, take_ready,
        input  cond_ready, take_valid, take, flags_out, taken_cnt
    );

    modport slave (
        input  flag_we, z_in, n_in, c_in, v_in, cond_valid, cond, take_ready,
        output cond_ready, take_valid, take, flags_out, taken_cnt
    );
endinterface

// File: rtl/flag_cond_unit.sv
// Status register plus condition-code evaluator with a one-deep
// valid/ready result stage and a counter of delivered taken results.
module flag_cond_unit #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input logic             clk,
    input logic             rst,
    flag_cond_unit_if.slave bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic             take_q, take_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       flags_in;
    logic [3:0]       eval_flags;
    logic             accept;
    logic             deliver;

    // Flags are held as {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = c;
            4'h3:    cond_eval = !c;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = c & !z;
            4'h9:    cond_eval = !c | z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z & (n == v);
            4'hD:    cond_eval = z | (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign flags_in       = {bus.n_in, bus.z_in, bus.c_in, bus.v_in};
    assign bus.take_valid = (state_q == S_HOLD);
    assign bus.take       = take_q;
    assign bus.cond_ready = !bus.take_valid | bus.take_ready;
    assign bus.flags_out  = flags_q;
    assign bus.taken_cnt  = cnt_q;

    assign accept     = bus.cond_valid & bus.cond_ready;
    assign deliver    = bus.take_valid & bus.take_ready;
    assign eval_flags = (BYPASS && bus.flag_we) ? flags_in : flags_q;

    // Next-state: flag latch, result stage FSM and taken counter.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        take_d  = take_q;
        cnt_d   = cnt_q;

        if (bus.flag_we) begin
            flags_d = flags_in;
        end

        if (accept) begin
            state_d = S_HOLD;
            take_d  = cond_eval(bus.cond, eval_flags);
        end else if (deliver) begin
            state_d = S_IDLE;
        end

        if (deliver && take_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset discarding any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            flags_q <= '0;
            take_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            take_q  <= take_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: a BYPASS=1/CNT_W=16 instance and a
// BYPASS=0/CNT_W=2 instance share one stimulus stream and are checked
// every cycle against a transaction-level model, plus directed literals.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_we = 1'b0;
    logic       z_in = 1'b0, n_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
    logic       cond_valid = 1'b0;
    logic [3:0] cond = 4'h0;
    logic       take_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flag_cond_unit_if #(.CNT_W(16)) if_a ();
    flag_cond_unit_if #(.CNT_W(2))  if_b ();

    assign if_a.flag_we = flag_we;    assign if_b.flag_we = flag_we;
    assign if_a.z_in = z_in;          assign if_b.z_in = z_in;
    assign if_a.n_in = n_in;          assign if_b.n_in = n_in;
    assign if_a.c_in = c_in;          assign if_b.c_in = c_in;
    assign if_a.v_in = v_in;          assign if_b.v_in = v_in;
    assign if_a.cond_valid = cond_valid; assign if_b.cond_valid = cond_valid;
    assign if_a.cond = cond;          assign if_b.cond = cond;
    assign if_a.take_ready = take_ready; assign if_b.take_ready = take_ready;

    flag_cond_unit #(.BYPASS(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    flag_cond_unit #(.BYPASS(1'b0), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: condition truth from pairs of complementary codes.
    function automatic bit cond_true(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    // Model state per instance: index 0 = dut_a, 1 = dut_b.
    logic [3:0]  m_flags [2];
    bit          m_valid [2];
    bit          m_take  [2];
    int unsigned m_cnt   [2];
    bit          live = 1'b0;

    // Model advance on each rising edge from the inputs held across it.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit          byp;
            int unsigned modulus;
            logic [3:0]  inc;
            bit          acc;
            byp     = (k == 0);
            modulus = (k == 0) ? 32'd65536 : 32'd4;
            inc     = {n_in, z_in, c_in, v_in};
            if (rst) begin
                m_flags[k] = 4'h0; m_valid[k] = 0; m_take[k] = 0; m_cnt[k] = 0;
            end else begin
                acc = cond_valid && (!m_valid[k] || take_ready);
                if (m_valid[k] && take_ready && m_take[k])
                    m_cnt[k] = (m_cnt[k] + 1) % modulus;
                if (acc) begin
                    m_take[k]  = cond_true(cond, (byp && flag_we) ? inc : m_flags[k]);
                    m_valid[k] = 1;
                end else if (take_ready) begin
                    m_valid[k] = 0;
                end
                if (flag_we) m_flags[k] = inc;
            end
        end
        if (rst) live = 1'b1;
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("a.take_valid", {31'd0, if_a.take_valid}, {31'd0, m_valid[0]});
            chk("a.cond_ready", {31'd0, if_a.cond_ready}, {31'd0, !m_valid[0] || take_ready});
            chk("a.flags_out",  {28'd0, if_a.flags_out}, {28'd0, m_flags[0]});
            chk("a.taken_cnt",  {16'd0, if_a.taken_cnt}, m_cnt[0]);
            if (m_valid[0]) chk("a.take", {31'd0, if_a.take}, {31'd0, m_take[0]});
            chk("b.take_valid", {31'd0, if_b.take_valid}, {31'd0, m_valid[1]});
            chk("b.cond_ready", {31'd0, if_b.cond_ready}, {31'd0, !m_valid[1] || take_ready});
            chk("b.flags_out",  {28'd0, if_b.flags_out}, {28'd0, m_flags[1]});
            chk("b.taken_cnt",  {30'd0, if_b.taken_cnt}, m_cnt[1]);
            if (m_valid[1]) chk("b.take", {31'd0, if_b.take}, {31'd0, m_take[1]});
        end
    end

    // Advance one cycle; inputs change just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_flags(input bit we, input logic [3:0] nzcv);
        flag_we = we;
        {n_in, z_in, c_in, v_in} = nzcv;
    endtask

    task automatic do_reset();
        rst = 1'b1; flag_we = 0; cond_valid = 0; take_ready = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst.flags",   {28'd0, if_a.flags_out}, 32'h0);
        chk("rst.tvalid",  {31'd0, if_a.take_valid}, 32'h0);
        chk("rst.cnt",     {16'd0, if_a.taken_cnt}, 32'h0);

        // Latch Z, then EQ is taken
        set_flags(1, 4'b0100); tick();
        chk("lit.flags_z", {28'd0, if_a.flags_out}, 32'h4);
        set_flags(0, 4'b0000); cond_valid = 1; cond = 4'h0; take_ready = 1; tick();
        chk("lit.eq_valid", {31'd0, if_a.take_valid}, 32'h1);
        chk("lit.eq_take",  {31'd0, if_a.take}, 32'h1);
        cond_valid = 0; tick();
        chk("lit.eq_cnt",   {16'd0, if_a.taken_cnt}, 32'h1);

        // Same-cycle flag write and GE: bypass vs latched flags
        do_reset();
        take_ready = 1; set_flags(1, 4'b1000); cond_valid = 1; cond = 4'hA; tick();
        chk("lit.ge_bypass", {31'd0, if_a.take}, 32'h0);
        chk("lit.ge_nobyp",  {31'd0, if_b.take}, 32'h1);

        // Backpressure hold, with a flag write in the middle
        set_flags(0, 4'b0000); take_ready = 0; cond = 4'hE;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_flags(1, 4'b0110); else set_flags(0, 4'b0000);
            #1;
            chk("lit.hold_rdy", {31'd0, if_a.cond_ready}, 32'h0);
            tick();
            chk("lit.hold_tv",   {31'd0, if_a.take_valid}, 32'h1);
            chk("lit.hold_take", {31'd0, if_a.take}, 32'h0);
        end
        chk("lit.hold_flags", {28'd0, if_a.flags_out}, 32'h6);
        cond_valid = 0; take_ready = 1; tick();
        chk("lit.release_tv", {31'd0, if_a.take_valid}, 32'h0);

        // Back-to-back AL/NV
        do_reset();
        take_ready = 1; cond_valid = 1;
        for (int i = 0; i < 4; i++) begin
            cond = (i % 2 == 0) ? 4'hE : 4'hF;
            tick();
            chk("lit.b2b_take", {31'd0, if_a.take}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        cond_valid = 0; tick();
        chk("lit.b2b_cnt", {16'd0, if_a.taken_cnt}, 32'h2);

        // Sweep every condition against every flag combination
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                set_flags(1, f[3:0]); cond_valid = 1; cond = c[3:0]; take_ready = 1;
                tick();
                if (c == 14) chk("lit.al", {31'd0, if_a.take}, 32'h1);
                if (c == 15) chk("lit.nv", {31'd0, if_a.take}, 32'h0);
            end
        end

        // Reset while holding a result
        set_flags(1, 4'b1111); cond = 4'hE; take_ready = 0; tick();
        rst = 1; tick(); rst = 0;
        chk("lit.rst_tv",    {31'd0, if_a.take_valid}, 32'h0);
        chk("lit.rst_flags", {28'd0, if_a.flags_out}, 32'h0);
        chk("lit.rst_cnt",   {16'd0, if_a.taken_cnt}, 32'h0);

        // Five taken transfers wrap the 2-bit counter
        set_flags(0, 4'b0000); take_ready = 1; cond_valid = 1; cond = 4'hE;
        for (int i = 0; i < 5; i++) tick();
        cond_valid = 0; tick();
        chk("lit.wrap_b", {30'd0, if_b.taken_cnt}, 32'h1);
        chk("lit.cnt_a5", {16'd0, if_a.taken_cnt}, 32'h5);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            flag_we    = ($urandom_range(0, 2) == 0);
            {n_in, z_in, c_in, v_in} = 4'($urandom);
            cond_valid = ($urandom_range(0, 3) != 0);
            cond       = 4'($urandom);
            take_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
